cordic_sched: RTL and testbench
===============================

Name: cordic_sched

Overview:
- Round-robin scheduler that shares one `cordic` core between N_REQ independent angle requesters.
- Each requester posts a single-cycle request carrying a theta. The scheduler latches the theta, grants requesters in turn, and drives the core's four-phase req/ack handshake.
- Each result (sin/cos) is returned to its originator with a one-cycle ack.
- A watchdog aborts transactions if the core stops responding.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 20, signed theta/sin/cos width; matches the `cordic` core.
- TIMEOUT, 64, maximum cycles spent in either handshake phase before abort.
- IDW, 2, requester id width, ceil(log2(N_REQ)).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  N_REQ  per-requester single-cycle request strobe
- i_theta  in  N_REQ*W  per-requester signed theta, slice k = [k*W +: W]; sampled with i_req[k]
- o_busy  out  N_REQ  requester k has a pending or in-flight request
- o_ack  out  N_REQ  one-cycle result strobe to requester k
- o_err  out  1  high with o_ack when the transaction timed out
- o_id  out  IDW  id of the requester being served / acked
- o_sin  out  W  signed result, valid while any o_ack bit is high
- o_cos  out  W  signed result, valid while any o_ack bit is high
- o_cordic_req  out  1  request to the core
- o_cordic_theta  out  W  theta to the core; stable while o_cordic_req is high
- i_cordic_sin  in  W  core result
- i_cordic_cos  in  W  core result
- i_cordic_ack  in  1  core ack (level)

Behaviour:
- Reset is synchronous. On the clock edge with i_rst=1, every register clears, including mid-transaction:
  - o_busy=0, o_ack=0, o_err=0, o_id=0, o_sin=0, o_cos=0
  - o_cordic_req=0, o_cordic_theta=0
  - pending=0, rr pointer=0, state=IDLE, watchdog=0
- Intake (every cycle, any state):
  - i_req[k]=1 with pending[k]=0: set pending[k] and latch theta_k.
  - i_req[k]=1 with pending[k]=1: ignored; the latched theta is unchanged.
  - Multiple requesters may post in the same cycle.
- o_busy[k] = pending[k], registered; it rises the cycle after i_req[k].
- Arbitration happens in IDLE only. The scheduler picks the first pending index at or after the rr pointer, wrapping modulo N_REQ.
- States:
  - IDLE: if any pending, record id and drive o_cordic_theta = theta_id, o_cordic_req=1, go to ISSUE. Otherwise stay.
  - ISSUE: hold req/theta. On i_cordic_ack=1, capture i_cordic_sin/cos into o_sin/o_cos, drop o_cordic_req, go to RELEASE.
  - RELEASE: wait for i_cordic_ack=0, then go to DONE.
  - DONE: for exactly one cycle:
    - o_ack[id]=1
    - pending[id] cleared
    - rr pointer = id+1, wrapping at N_REQ
    - return to IDLE
- Minimum latency from i_req to o_ack is 4 cycles plus the core's ack delay. A new grant can start the cycle after DONE.
- Watchdog:
  - Counter clears on each state entry and increments in ISSUE and RELEASE.
  - Reaching TIMEOUT forces o_cordic_req=0 and a jump to DONE with o_err=1 and o_sin=o_cos=0.
  - Pending is still cleared and rr still advances.
- A request from requester id arriving in its own DONE cycle is accepted, because pending clears before intake is evaluated (intake wins).
- An i_cordic_ack seen in IDLE or DONE is ignored.
- Arithmetic: pass-through only, no scaling. Widths are W-bit signed throughout.

Decomposition:
- Package `cordic_sched_pkg`:
  - state enum IDLE/ISSUE/RELEASE/DONE
  - W default
  - watchdog counter width, clog2(TIMEOUT+1)
- Sub-module `rr_pick`: combinational round-robin pick.
  - Inputs: pending vector and pointer.
  - Outputs: grant id and valid.
- All remaining logic stays in `cordic_sched`.

Test Plan:
- Single request: reset, then i_req[0] with theta=-205887 (-pi); bench core acks 5 cycles after req → o_cordic_theta=-205887, one o_ack[0] pulse, o_id=0, o_sin/o_cos equal the core values, o_busy[0] falls with the ack.
- Simultaneous requests: i_req=4'b1111 in one cycle, thetas 0/100/200/300 → served in order 0,1,2,3, one ack each, no overlap on o_cordic_req.
- Fairness: rr=2 and requesters 0 and 3 pending → 3 is served before 0. Requester 1 re-posting continuously never starves 2.
- Duplicate request: i_req[1] with theta=100, then theta=555 while busy → core sees 100, a single ack is produced, 555 is dropped.
- Timeout: core never acks → o_cordic_req drops after TIMEOUT=64 cycles, o_ack plus o_err pulse with sin=cos=0, and the next pending requester is served normally.
- Reset mid-ISSUE: assert i_rst for one cycle → o_cordic_req=0 on the next edge, all o_busy=0, no ack, and a fresh request afterwards completes normally.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// Shared types and defaults for the cordic_sched scheduler and its helpers.
package cordic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int W_DEFAULT       = 20;
    localparam int TIMEOUT_DEFAULT = 64;

    // The watchdog must be able to hold the value TIMEOUT itself.
    function automatic int wdWidth(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int WDW_DEFAULT = wdWidth(TIMEOUT_DEFAULT);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending index at or after the pointer.
module rr_pick
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [IDW-1:0]   i_ptr,
    output logic [IDW-1:0]   o_id,
    output logic             o_valid
);

    int               w_idx;
    logic [N_REQ-1:0] w_shifted;

    // Walk the offsets from farthest to nearest so the nearest pending
    // requester (in wrap-around order from the pointer) overwrites the rest.
    always_comb begin
        o_id      = '0;
        o_valid   = 1'b0;
        w_idx     = 0;
        w_shifted = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_shifted = i_pending >> w_idx;
            if (w_shifted[0]) begin
                o_id    = IDW'(w_idx);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one cordic core between N_REQ requesters,
// with a four-phase req/ack handshake to the core and a watchdog abort.
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int IDW     = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*W-1:0] i_theta,
    output logic [N_REQ-1:0]   o_busy,
    output logic [N_REQ-1:0]   o_ack,
    output logic               o_err,
    output logic [IDW-1:0]     o_id,
    output logic [W-1:0]       o_sin,
    output logic [W-1:0]       o_cos,
    output logic               o_cordic_req,
    output logic [W-1:0]       o_cordic_theta,
    input  logic [W-1:0]       i_cordic_sin,
    input  logic [W-1:0]       i_cordic_cos,
    input  logic               i_cordic_ack
);

    localparam int WDW = wdWidth(TIMEOUT);

    state_t           r_state;
    logic [N_REQ-1:0] r_pending;
    logic [W-1:0]     r_theta [N_REQ];
    logic [IDW-1:0]   r_rrPtr;
    logic [IDW-1:0]   r_id;
    logic [WDW-1:0]   r_wd;
    logic [N_REQ-1:0] r_ack;
    logic             r_err;
    logic [W-1:0]     r_sin;
    logic [W-1:0]     r_cos;
    logic             r_cordicReq;
    logic [W-1:0]     r_cordicTheta;

    logic [IDW-1:0]   w_grantId;
    logic             w_grantValid;
    logic             w_wdExpired;
    logic             w_enterDone;
    logic [N_REQ-1:0] w_idOneHot;
    logic [N_REQ-1:0] w_pendingKept;
    logic [N_REQ-1:0] w_accept;
    logic [IDW-1:0]   w_nextPtr;
    logic [W-1:0]     w_thetaNext [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_rrPtr),
        .o_id      (w_grantId),
        .o_valid   (w_grantValid)
    );

    assign w_wdExpired = (r_wd == WDW'(TIMEOUT));
    assign w_idOneHot  = N_REQ'(1) << r_id;
    assign w_nextPtr   = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;

    // The edge that moves into DONE is the one that retires the served
    // requester, whether the core answered or the watchdog fired.
    assign w_enterDone = ((r_state == ISSUE) && !i_cordic_ack && w_wdExpired) ||
                         ((r_state == RELEASE) && (!i_cordic_ack || w_wdExpired));

    // Retirement is applied before intake, so a requester re-posting on its
    // own completion edge is accepted as a fresh request.
    assign w_pendingKept = r_pending & ~(w_enterDone ? w_idOneHot : '0);
    assign w_accept      = i_req & ~w_pendingKept;

    genvar k;
    generate
        for (k = 0; k < N_REQ; k++) begin : g_thetaNext
            assign w_thetaNext[k] = w_accept[k] ? i_theta[k*W +: W] : r_theta[k];
        end
    endgenerate

    // Request intake: latch theta only when a requester has nothing pending,
    // so duplicate posts while busy are silently dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
            r_theta   <= '{default: '0};
        end else begin
            r_pending <= w_pendingKept | i_req;
            r_theta   <= w_thetaNext;
        end
    end

    // Main handshake FSM: grant in IDLE, hold req until the core acks, wait
    // for the ack to drop, then pulse the result back for one cycle. The
    // watchdog restarts on every state entry and aborts a stuck phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_rrPtr       <= '0;
            r_id          <= '0;
            r_wd          <= '0;
            r_ack         <= '0;
            r_err         <= 1'b0;
            r_sin         <= '0;
            r_cos         <= '0;
            r_cordicReq   <= 1'b0;
            r_cordicTheta <= '0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wd <= '0;
                    if (w_grantValid) begin
                        r_id          <= w_grantId;
                        r_cordicTheta <= r_theta[w_grantId];
                        r_cordicReq   <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_cordic_ack) begin
                        r_sin       <= i_cordic_sin;
                        r_cos       <= i_cordic_cos;
                        r_cordicReq <= 1'b0;
                        r_wd        <= '0;
                        r_state     <= RELEASE;
                    end else if (w_wdExpired) begin
                        r_cordicReq <= 1'b0;
                        r_sin       <= '0;
                        r_cos       <= '0;
                        r_err       <= 1'b1;
                        r_ack       <= w_idOneHot;
                        r_rrPtr     <= w_nextPtr;
                        r_wd        <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!i_cordic_ack) begin
                        r_ack   <= w_idOneHot;
                        r_rrPtr <= w_nextPtr;
                        r_wd    <= '0;
                        r_state <= DONE;
                    end else if (w_wdExpired) begin
                        r_sin   <= '0;
                        r_cos   <= '0;
                        r_err   <= 1'b1;
                        r_ack   <= w_idOneHot;
                        r_rrPtr <= w_nextPtr;
                        r_wd    <= '0;
                        r_state <= DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                DONE: begin
                    r_wd    <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy         = r_pending;
    assign o_ack          = r_ack;
    assign o_err          = r_err;
    assign o_id           = r_id;
    assign o_sin          = r_sin;
    assign o_cos          = r_cos;
    assign o_cordic_req   = r_cordicReq;
    assign o_cordic_theta = r_cordicTheta;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed self-checking bench for cordic_sched with a behavioural cordic core.
module tb_cordic_sched;

    localparam int N       = 4;
    localparam int W       = 20;
    localparam int TIMEOUT = 64;
    localparam logic [W-1:0] SIN_MASK = 20'h0F0F0;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   theta;
    logic [N-1:0]     oBusy;
    logic [N-1:0]     oAck;
    logic             oErr;
    logic [1:0]       oId;
    logic [W-1:0]     oSin;
    logic [W-1:0]     oCos;
    logic             oCordicReq;
    logic [W-1:0]     oCordicTheta;
    logic [W-1:0]     coreSin;
    logic [W-1:0]     coreCos;
    logic             coreAck;

    int  coreDelay;
    bit  coreNoAck;
    int  coreCnt;

    int  testsRun;
    int  testsFailed;

    int           ackId[$];
    logic         ackErr[$];
    logic [W-1:0] ackSin[$];
    logic [W-1:0] ackCos[$];
    logic         ackReqHigh[$];
    logic [W-1:0] grantTheta[$];
    int           reqLen[$];
    int           reqRun;
    logic         prevReq;
    int           ackMulti;
    int           errNoAck;

    cordic_sched #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (TIMEOUT),
        .IDW     (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_theta        (theta),
        .o_busy         (oBusy),
        .o_ack          (oAck),
        .o_err          (oErr),
        .o_id           (oId),
        .o_sin          (oSin),
        .o_cos          (oCos),
        .o_cordic_req   (oCordicReq),
        .o_cordic_theta (oCordicTheta),
        .i_cordic_sin   (coreSin),
        .i_cordic_cos   (coreCos),
        .i_cordic_ack   (coreAck)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never completes.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before limit");
        $fatal(1, "[TB] global timeout");
    end

    function automatic logic [W-1:0] expSin(input logic [W-1:0] t);
        return t ^ SIN_MASK;
    endfunction

    function automatic logic [W-1:0] expCos(input logic [W-1:0] t);
        return ~t;
    endfunction

    // Behavioural core: raises ack coreDelay cycles after req, holds it until
    // req drops, and parks junk on its result lines when idle.
    always @(posedge clk) begin
        if (rst) begin
            coreAck <= 1'b0;
            coreCnt <= 0;
            coreSin <= '0;
            coreCos <= '0;
        end else if (oCordicReq && !coreNoAck) begin
            if (coreCnt >= coreDelay - 1) begin
                coreAck <= 1'b1;
                coreSin <= expSin(oCordicTheta);
                coreCos <= expCos(oCordicTheta);
            end else begin
                coreCnt <= coreCnt + 1;
            end
        end else if (!oCordicReq) begin
            coreAck <= 1'b0;
            coreCnt <= 0;
            coreSin <= 20'h33333;
            coreCos <= 20'h44444;
        end
    end

    // Passive monitor: logs every ack pulse and every grant to the core.
    always @(negedge clk) begin
        int id;
        id = 0;
        if (|oAck) begin
            for (int k = 0; k < N; k++) begin
                if (oAck[k]) id = k;
            end
            ackId.push_back(id);
            ackErr.push_back(oErr);
            ackSin.push_back(oSin);
            ackCos.push_back(oCos);
            ackReqHigh.push_back(oCordicReq);
            if ($countones(oAck) > 1) ackMulti++;
        end
        if (oErr && !(|oAck)) errNoAck++;
        if (oCordicReq && !prevReq) grantTheta.push_back(oCordicTheta);
        if (oCordicReq) begin
            reqRun++;
        end else if (prevReq) begin
            reqLen.push_back(reqRun);
            reqRun = 0;
        end
        prevReq = oCordicReq;
    end

    task automatic clearLogs();
        ackId.delete();
        ackErr.delete();
        ackSin.delete();
        ackCos.delete();
        ackReqHigh.delete();
        grantTheta.delete();
        reqLen.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        coreNoAck = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reqRun = 0;
    endtask

    task automatic postReq(input logic [N-1:0] mask, input logic [W-1:0] t0,
                           input logic [W-1:0] t1, input logic [W-1:0] t2,
                           input logic [W-1:0] t3);
        @(negedge clk);
        req   = mask;
        theta = {t3, t2, t1, t0};
        @(negedge clk);
        req   = '0;
        theta = {N{20'h5A5A5}};
    endtask

    task automatic waitAcks(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (ackId.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        ok = (ackId.size() >= n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '1;
        theta = {N{20'h12345}};
        repeat (3) @(negedge clk);
        req = '0;
        rst = 1'b0;
        testsRun++;
        if (oBusy !== 4'b0000 || oAck !== 4'b0000 || oErr !== 1'b0 || oId !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: busy=%b ack=%b err=%b id=%0d, required 0/0/0/0", oBusy, oAck, oErr, oId);
        end
        testsRun++;
        if (oSin !== '0 || oCos !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: sin=%h cos=%h, required 0/0", oSin, oCos);
        end
        testsRun++;
        if (oCordicReq !== 1'b0 || oCordicTheta !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_core: req=%b theta=%h, required 0/0", oCordicReq, oCordicTheta);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] th;
        int lat;
        th = -20'sd205887;
        doReset();
        coreDelay = 5;
        clearLogs();
        @(negedge clk);
        req = 4'b0001;
        theta = {60'h0, th};
        @(negedge clk);
        req = '0;
        theta = {N{20'h5A5A5}};
        lat = 1;
        testsRun++;
        if (oBusy !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL single_busy_rise: busy=%b, required 0001", oBusy);
        end
        while (!oAck[0] && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        testsRun++;
        if (lat !== 10) begin
            testsFailed++;
            $display("[TB] FAIL single_latency: %0d cycles, required 10", lat);
        end
        testsRun++;
        if (oId !== 2'd0 || oErr !== 1'b0 || oAck !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL single_ack: id=%0d err=%b ack=%b, required 0/0/0001", oId, oErr, oAck);
        end
        testsRun++;
        if (oSin !== expSin(th) || oCos !== expCos(th)) begin
            testsFailed++;
            $display("[TB] FAIL single_result: sin=%h cos=%h, required %h/%h", oSin, oCos, expSin(th), expCos(th));
        end
        testsRun++;
        if (oBusy !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL single_busy_fall: busy=%b, required 0000", oBusy);
        end
        repeat (15) @(negedge clk);
        testsRun++;
        if (grantTheta.size() !== 1 || ackId.size() !== 1) begin
            testsFailed++;
            $display("[TB] FAIL single_counts: grants=%0d acks=%0d, required 1/1", grantTheta.size(), ackId.size());
        end else begin
            testsRun++;
            if (grantTheta[0] !== th) begin
                testsFailed++;
                $display("[TB] FAIL single_core_theta: %h, required %h", grantTheta[0], th);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [W-1:0] e;
        doReset();
        coreDelay = 2;
        clearLogs();
        postReq(4'b1111, 20'd0, 20'd100, 20'd200, 20'd300);
        waitAcks(4, 200, ok);
        repeat (10) @(negedge clk);
        testsRun++;
        if (!ok || ackId.size() !== 4 || grantTheta.size() !== 4) begin
            testsFailed++;
            $display("[TB] FAIL simul_counts: acks=%0d grants=%0d, required 4/4", ackId.size(), grantTheta.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = 20'(i * 100);
                testsRun++;
                if (ackId[i] !== i || grantTheta[i] !== e || ackErr[i] !== 1'b0 || ackReqHigh[i] !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL simul_order_%0d: id=%0d theta=%h err=%b req=%b, required %0d/%h/0/0",
                             i, ackId[i], grantTheta[i], ackErr[i], ackReqHigh[i], i, e);
                end
                testsRun++;
                if (ackSin[i] !== expSin(e) || ackCos[i] !== expCos(e)) begin
                    testsFailed++;
                    $display("[TB] FAIL simul_result_%0d: sin=%h cos=%h, required %h/%h",
                             i, ackSin[i], ackCos[i], expSin(e), expCos(e));
                end
            end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int c;
        doReset();
        coreDelay = 1;
        clearLogs();
        postReq(4'b0010, 20'd0, 20'd11, 20'd0, 20'd0);
        waitAcks(1, 60, ok);
        postReq(4'b1001, 20'd22, 20'd0, 20'd0, 20'd33);
        waitAcks(3, 100, ok);
        testsRun++;
        if (!ok || ackId.size() < 3 || grantTheta.size() < 3) begin
            testsFailed++;
            $display("[TB] FAIL fair_counts: acks=%0d grants=%0d, required 3/3", ackId.size(), grantTheta.size());
        end else begin
            testsRun++;
            if (ackId[1] !== 3 || ackId[2] !== 0 || grantTheta[1] !== 20'd33 || grantTheta[2] !== 20'd22) begin
                testsFailed++;
                $display("[TB] FAIL fair_wrap: ids=%0d,%0d thetas=%h,%h, required 3,0 / 21,16",
                         ackId[1], ackId[2], grantTheta[1], grantTheta[2]);
            end
        end
        doReset();
        clearLogs();
        @(negedge clk);
        req = 4'b0110;
        theta = {20'd0, 20'd55, 20'd44, 20'd0};
        c = 0;
        while (ackId.size() < 3 && c < 200) begin
            @(negedge clk);
            req = 4'b0010;
            theta = {20'd0, 20'd99, 20'd44, 20'd0};
            c++;
        end
        req = '0;
        repeat (2) @(negedge clk);
        testsRun++;
        if (ackId.size() < 3 || grantTheta.size() < 3) begin
            testsFailed++;
            $display("[TB] FAIL starve_counts: acks=%0d grants=%0d, required >=3", ackId.size(), grantTheta.size());
        end else begin
            testsRun++;
            if (ackId[0] !== 1 || ackId[1] !== 2 || ackId[2] !== 1 || grantTheta[1] !== 20'd55) begin
                testsFailed++;
                $display("[TB] FAIL starve_order: ids=%0d,%0d,%0d theta2=%h, required 1,2,1 / 37",
                         ackId[0], ackId[1], ackId[2], grantTheta[1]);
            end
        end
    endtask

    task automatic test_duplicate();
        bit ok;
        doReset();
        coreDelay = 5;
        clearLogs();
        postReq(4'b0010, 20'd0, 20'd100, 20'd0, 20'd0);
        postReq(4'b0010, 20'd0, 20'd555, 20'd0, 20'd0);
        waitAcks(1, 100, ok);
        repeat (30) @(negedge clk);
        testsRun++;
        if (!ok || ackId.size() !== 1 || grantTheta.size() !== 1) begin
            testsFailed++;
            $display("[TB] FAIL dup_counts: acks=%0d grants=%0d, required 1/1", ackId.size(), grantTheta.size());
        end else begin
            testsRun++;
            if (ackId[0] !== 1 || grantTheta[0] !== 20'd100 || ackSin[0] !== expSin(20'd100)) begin
                testsFailed++;
                $display("[TB] FAIL dup_theta: id=%0d theta=%h sin=%h, required 1/64/%h",
                         ackId[0], grantTheta[0], ackSin[0], expSin(20'd100));
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        doReset();
        coreDelay = 2;
        coreNoAck = 1'b1;
        clearLogs();
        postReq(4'b0101, 20'd7, 20'd0, 20'd9, 20'd0);
        waitAcks(1, 200, ok);
        coreNoAck = 1'b0;
        waitAcks(2, 100, ok);
        testsRun++;
        if (!ok || ackId.size() !== 2 || reqLen.size() < 1) begin
            testsFailed++;
            $display("[TB] FAIL tmo_counts: acks=%0d runs=%0d, required 2/>=1", ackId.size(), reqLen.size());
        end else begin
            testsRun++;
            if (ackId[0] !== 0 || ackErr[0] !== 1'b1 || ackSin[0] !== '0 || ackCos[0] !== '0) begin
                testsFailed++;
                $display("[TB] FAIL tmo_abort: id=%0d err=%b sin=%h cos=%h, required 0/1/0/0",
                         ackId[0], ackErr[0], ackSin[0], ackCos[0]);
            end
            testsRun++;
            if (reqLen[0] < TIMEOUT || reqLen[0] > TIMEOUT + 1) begin
                testsFailed++;
                $display("[TB] FAIL tmo_length: req high %0d cycles, required %0d..%0d", reqLen[0], TIMEOUT, TIMEOUT + 1);
            end
            testsRun++;
            if (ackId[1] !== 2 || ackErr[1] !== 1'b0 || ackSin[1] !== expSin(20'd9) || ackCos[1] !== expCos(20'd9)) begin
                testsFailed++;
                $display("[TB] FAIL tmo_next: id=%0d err=%b sin=%h cos=%h, required 2/0/%h/%h",
                         ackId[1], ackErr[1], ackSin[1], ackCos[1], expSin(20'd9), expCos(20'd9));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c;
        doReset();
        coreDelay = 20;
        clearLogs();
        postReq(4'b0011, 20'd1, 20'd2, 20'd0, 20'd0);
        c = 0;
        while (!oCordicReq && c < 20) begin
            @(negedge clk);
            c++;
        end
        testsRun++;
        if (oCordicReq !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_issue: req=%b, required 1", oCordicReq);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        testsRun++;
        if (oCordicReq !== 1'b0 || oBusy !== 4'b0000 || oAck !== 4'b0000 || oErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_clear: req=%b busy=%b ack=%b err=%b, required 0/0000/0000/0",
                     oCordicReq, oBusy, oAck, oErr);
        end
        clearLogs();
        repeat (30) @(negedge clk);
        testsRun++;
        if (ackId.size() !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_noack: acks=%0d, required 0", ackId.size());
        end
        coreDelay = 3;
        postReq(4'b0100, 20'd0, 20'd0, 20'd1234, 20'd0);
        waitAcks(1, 60, ok);
        testsRun++;
        if (!ok || ackId.size() !== 1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_fresh_count: acks=%0d, required 1", ackId.size());
        end else begin
            testsRun++;
            if (ackId[0] !== 2 || ackErr[0] !== 1'b0 || ackSin[0] !== expSin(20'd1234)) begin
                testsFailed++;
                $display("[TB] FAIL midrst_fresh: id=%0d err=%b sin=%h, required 2/0/%h",
                         ackId[0], ackErr[0], ackSin[0], expSin(20'd1234));
            end
        end
    endtask

    task automatic test_ack_shape();
        testsRun++;
        if (ackMulti !== 0 || errNoAck !== 0) begin
            testsFailed++;
            $display("[TB] FAIL ack_shape: multi-hot acks=%0d lone errs=%0d, required 0/0", ackMulti, errNoAck);
        end
    endtask

    // Test sequence.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        ackMulti    = 0;
        errNoAck    = 0;
        reqRun      = 0;
        prevReq     = 1'b0;
        coreDelay   = 5;
        coreNoAck   = 1'b0;
        rst         = 1'b1;
        req         = '0;
        theta       = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_duplicate();
        test_timeout();
        test_reset_mid();
        test_ack_shape();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
